// File: rtl/aes_round_ctrl_if.sv
// Handshake and round-control bundle between aes_round_ctrl (master) and its datapath (slave).
// mode_dec / inv_sel exist only when AES_ROUND_CTRL_DECRYPT_EN is defined.
interface aes_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       load_state;
  logic       state_en;
  logic       ark_only;
  logic       mixcol_bypass;
  logic [3:0] round_idx;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
  logic       mode_dec;
  logic       inv_sel;
`endif

  modport master (
    input  in_valid, out_ready,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    input  mode_dec,
    output inv_sel,
`endif
    output in_ready, load_state, state_en, ark_only, mixcol_bypass,
    output round_idx, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    output mode_dec,
    input  inv_sel,
`endif
    input  in_ready, load_state, state_en, ark_only, mixcol_bypass,
    input  round_idx, out_valid, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: IDLE -> INIT -> ROUND x(NR-1) -> FINAL -> DONE, one block at a time.
// Optional decrypt key ordering is enabled by defining AES_ROUND_CTRL_DECRYPT_EN.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input logic              clk,
  input logic              rst,
  aes_round_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [3:0] NR_W       = 4'(NR);
  localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dec_s;
  logic       in_ready_s, load_state_s, state_en_s, ark_only_s, mixcol_bypass_s;
  logic       out_valid_s, busy_s;
  logic [3:0] round_idx_s;

`ifdef AES_ROUND_CTRL_DECRYPT_EN
  logic inv_q, inv_d;
  assign dec_s       = inv_q;
  assign bus.inv_sel = inv_q & busy_s;
`else
  assign dec_s = 1'b0;
`endif

  // State, round counter and direction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // Next-state logic and per-state control decode
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    in_ready_s      = 1'b0;
    load_state_s    = 1'b0;
    state_en_s      = 1'b0;
    ark_only_s      = 1'b0;
    mixcol_bypass_s = 1'b0;
    out_valid_s     = 1'b0;
    round_idx_s     = 4'd0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    inv_d           = inv_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d        = 4'd0;
        in_ready_s   = ~rst;
        load_state_s = bus.in_valid & ~rst;
        if (load_state_s) begin
          state_d = INIT;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
          inv_d   = bus.mode_dec;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      INIT: begin
        state_en_s  = 1'b1;
        ark_only_s  = 1'b1;
        round_idx_s = dec_s ? NR_W : 4'd0;
        cnt_d       = 4'd1;
        state_d     = ROUND;
      end
      ROUND: begin
        state_en_s  = 1'b1;
        round_idx_s = dec_s ? (NR_W - cnt_q) : cnt_q;
        // >= so a corrupted counter still falls through to FINAL
        if (cnt_q >= LAST_ROUND) begin
          cnt_d   = 4'd0;
          state_d = FINAL;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ROUND;
        end
      end
      FINAL: begin
        state_en_s      = 1'b1;
        mixcol_bypass_s = 1'b1;
        round_idx_s     = dec_s ? 4'd0 : NR_W;
        state_d         = DONE;
      end
      DONE: begin
        out_valid_s = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy_s            = (state_q != IDLE);
  assign bus.in_ready      = in_ready_s;
  assign bus.load_state    = load_state_s;
  assign bus.state_en      = state_en_s;
  assign bus.ark_only      = ark_only_s;
  assign bus.mixcol_bypass = mixcol_bypass_s;
  assign bus.round_idx     = round_idx_s;
  assign bus.out_valid     = out_valid_s;
  assign bus.busy          = busy_s;
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, SHALL set the number of AES rounds; legal values are 10, 12 and 14.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-004 Port in_valid, input, 1 bit, SHALL indicate that a block is offered to the round datapath.
REQ-005 Port in_ready, output, 1 bit, SHALL indicate that the controller accepts a block.
REQ-006 Port load_state, output, 1 bit, SHALL tell the datapath to capture the input block into its state register.
REQ-007 Port state_en, output, 1 bit, SHALL enable a state-register update with the round result.
REQ-008 Port ark_only, output, 1 bit, SHALL select the AddRoundKey-only path (initial round).
REQ-009 Port mixcol_bypass, output, 1 bit, SHALL bypass MixColumns (final round).
REQ-010 Port round_idx, output, 4 bits, SHALL give the round-key index to the key schedule.
REQ-011 Port out_valid, output, 1 bit, SHALL indicate that the datapath state holds a finished block.
REQ-012 Port out_ready, input, 1 bit, SHALL indicate that the consumer takes the result.
REQ-013 Port busy, output, 1 bit, SHALL be high in every state except IDLE.

Function
REQ-014 The FSM states SHALL be IDLE, INIT, ROUND, FINAL and DONE.
REQ-015 in_ready SHALL equal (state==IDLE); accept = in_valid & in_ready.
REQ-016 On accept: load_state pulses high for that cycle only, and the next state is INIT.
REQ-017 INIT, 1 cycle: state_en=1, ark_only=1, round_idx=0; next state is ROUND.
REQ-018 ROUND, NR-1 cycles: state_en=1, round_idx counts 1..NR-1; after round_idx==NR-1 the next state is FINAL.
REQ-019 FINAL, 1 cycle: state_en=1, mixcol_bypass=1, round_idx=NR; next state is DONE.
REQ-020 DONE: out_valid=1, held until out_valid & out_ready, then the next state is IDLE.
REQ-021 Accept at cycle t SHALL give out_valid first high at cycle t+NR+2.
REQ-022 Throughput SHALL be one block per NR+3 cycles minimum; there is no overlap of blocks.
REQ-023 in_valid outside IDLE SHALL be ignored.
REQ-024 out_ready while out_valid=0 SHALL be ignored.
REQ-025 ark_only, mixcol_bypass and state_en SHALL never be high outside INIT/ROUND/FINAL.
REQ-026 ark_only and mixcol_bypass SHALL never be high together.
REQ-027 round_idx SHALL be 0 in IDLE and DONE.
REQ-028 An in_valid/out_ready combination in DONE SHALL NOT accept a new block in the same cycle; the earliest accept is the next cycle, in IDLE.

Reset
REQ-029 rst high SHALL force state IDLE at the next clock edge, regardless of current state.
REQ-030 After reset, outputs SHALL be: out_valid=0, load_state=0, state_en=0, ark_only=0, mixcol_bypass=0, round_idx=0, busy=0, in_ready=1 once rst is low.
REQ-031 Reset mid-operation SHALL discard the block; no out_valid is produced for it.

Configuration
REQ-032 Macro AES_ROUND_CTRL_DECRYPT_EN, when defined, SHALL add input mode_dec (1 bit) and output inv_sel (1 bit).
REQ-033 With AES_ROUND_CTRL_DECRYPT_EN defined, mode_dec is sampled at accept; if 1, inv_sel=1 for INIT through DONE and round_idx runs NR (INIT), NR-1..1 (ROUND), 0 (FINAL); state sequence and timing are unchanged.
REQ-034 Without AES_ROUND_CTRL_DECRYPT_EN, mode_dec and inv_sel SHALL be absent and only encryption ordering applies.

Verification
REQ-035 NR=10, reset then single accept at t with out_ready=1 -> load_state@t; ark_only@t+1 with round_idx=0; round_idx 1..9 @t+2..t+10; mixcol_bypass @t+11 with round_idx=10; out_valid @t+12 for 1 cycle; in_ready @t+13.
REQ-036 With the FIPS-197 datapath attached, key 000102030405060708090a0b0c0d0e0f and pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 out_ready held low for 5 cycles after out_valid -> out_valid stays high for 6 cycles, in_ready=0 and in_valid ignored throughout.
REQ-038 rst pulsed at t+6 of a block -> IDLE at t+7, all outputs at reset values, and no out_valid for that block.
REQ-039 NR=14 back-to-back blocks with in_valid held high -> accepts 17 cycles apart, round_idx peaks at 14.
REQ-040 AES_ROUND_CTRL_DECRYPT_EN defined, mode_dec=1, NR=10 -> round_idx sequence 10,9..1,0 with inv_sel high from t+1 to the out_valid handshake.
